branch_cond_fifo: RTL and testbench



---
 rtl/branch_cond_fifo_pkg.sv | 19 +
 rtl/branch_cond_fifo_if.sv | 34 +++
 rtl/cond_fifo.sv | 77 +++++++
 rtl/branch_cond_fifo.sv | 92 +++++++++
 tb/tb_branch_cond_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_cond_fifo_pkg.sv
// Shared constants for the branch-condition evaluator: condition-kind encodings and stats width.
// No logic; pure definitions.
// Imported by the interface, the FIFO wrapper top and the bench.
package branch_cond_pkg;

  localparam int COND_KIND_W = 3;

  localparam logic [COND_KIND_W-1:0] COND_EQ     = 3'd0;
  localparam logic [COND_KIND_W-1:0] COND_NE     = 3'd1;
  localparam logic [COND_KIND_W-1:0] COND_LTZ    = 3'd2;
  localparam logic [COND_KIND_W-1:0] COND_GEZ    = 3'd3;
  localparam logic [COND_KIND_W-1:0] COND_GTZ    = 3'd4;
  localparam logic [COND_KIND_W-1:0] COND_LEZ    = 3'd5;
  localparam logic [COND_KIND_W-1:0] COND_ALWAYS = 3'd6;
  localparam logic [COND_KIND_W-1:0] COND_NEVER  = 3'd7;

  localparam int STAT_W = 16;

endpackage

// File: rtl/branch_cond_fifo_if.sv
// Request/result handshake bundle between the EX-stage operand bus and PC-select.
// Signals only; no latency of its own.
// Valid/ready on both the request side (in_*) and the result side (out_*).
interface branch_cond_fifo_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8
);
  import branch_cond_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [COND_KIND_W-1:0] in_kind;
  logic [DATA_W-1:0]      in_a;
  logic [DATA_W-1:0]      in_b;
  logic [TAG_W-1:0]       in_tag;

  logic                   out_valid;
  logic                   out_ready;
  logic                   out_taken;
  logic [TAG_W-1:0]       out_tag;

  // Requester / result consumer side
  modport master (
    output in_valid, in_kind, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_taken, out_tag
  );

  // Evaluator side
  modport slave (
    input  in_valid, in_kind, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_taken, out_tag
  );

endinterface

// File: rtl/cond_fifo.sv
// Generic result FIFO: DEPTH entries of WIDTH bits, separate occupancy count, flush clears all.
// Write visible at the output one cycle after the push edge; no bypass.
// push/pop are qualified internally by full/empty; flush overrides both, rst overrides flush.
module cond_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // An empty FIFO presents zeros so the head payload has a defined value without resetting storage.
  assign rdat_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  // Next-state pointers and count; flush collapses everything back to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written on accepted pushes only; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdat_i;
  end

endmodule

// File: rtl/branch_cond_fifo.sv
// Branch-condition evaluator: decodes one of eight kinds on operand A/B, queues {taken, tag}.
// Result visible on out_* one cycle after the accept edge (no bypass).
// in_ready drops when full or flushing; BRANCH_COND_STATS_EN adds saturating accept/taken counters.
module branch_cond_fifo
  import branch_cond_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  branch_cond_fifo_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
`ifdef BRANCH_COND_STATS_EN
  ,
  output logic [STAT_W-1:0]          stat_total_o,
  output logic [STAT_W-1:0]          stat_taken_o
`endif
);

  localparam int WIDTH = TAG_W + 1;

  logic [DATA_W-1:0] op_a, op_b;
  logic              a_neg, a_zero;
  logic              cond_taken;
  logic              accept, pop;
  logic              full, empty;
  logic [WIDTH-1:0]  head;

  assign op_a   = bus.in_a;
  assign op_b   = bus.in_b;
  assign a_neg  = op_a[DATA_W-1];
  assign a_zero = (op_a == '0);

  // Condition decode; the compare-to-zero kinds only need the sign bit and a zero detect.
  always_comb begin
    cond_taken = 1'b0;
    case (bus.in_kind)
      COND_EQ:     cond_taken = (op_a == op_b);
      COND_NE:     cond_taken = (op_a != op_b);
      COND_LTZ:    cond_taken = a_neg;
      COND_GEZ:    cond_taken = !a_neg;
      COND_GTZ:    cond_taken = !a_neg && !a_zero;
      COND_LEZ:    cond_taken = a_neg || a_zero;
      COND_ALWAYS: cond_taken = 1'b1;
      default:     cond_taken = 1'b0;
    endcase
  end

  assign bus.in_ready  = !full && !flush_i;
  assign bus.out_valid = !empty;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign {bus.out_taken, bus.out_tag} = head;

  cond_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (accept),
    .wdat_i  ({cond_taken, bus.in_tag}),
    .pop_i   (pop),
    .rdat_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

`ifdef BRANCH_COND_STATS_EN
  logic [STAT_W-1:0] stat_total_q, stat_taken_q;

  assign stat_total_o = stat_total_q;
  assign stat_taken_o = stat_taken_q;

  // Saturating accept/taken counters; only rst clears them, flush leaves history intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q <= '0;
      stat_taken_q <= '0;
    end else if (accept) begin
      if (stat_total_q != '1) stat_total_q <= stat_total_q + STAT_W'(1);
      if (cond_taken && (stat_taken_q != '1)) stat_taken_q <= stat_taken_q + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_cond_fifo.sv
// Bench for branch_cond_fifo: vector table for the condition kinds, hand sequences for
// fill/back-pressure, steady push+pop, flush and mid-stream reset; a scoreboard
// checks every popped {taken, tag} against what was queued when the request was driven.
module tb_branch_cond_fifo;
  import branch_cond_pkg::*;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;
`ifdef BRANCH_COND_STATS_EN
  logic [STAT_W-1:0] stat_total, stat_taken;
`endif

  branch_cond_fifo_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  branch_cond_fifo #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus),
    .count_o (count)
`ifdef BRANCH_COND_STATS_EN
    ,
    .stat_total_o (stat_total),
    .stat_taken_o (stat_taken)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             taken;
  } sb_t;

  sb_t  sbq[$];
  sb_t  mon_e;
  logic drv_exp = 1'b0;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic        exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) <  0;
      3'd3:    return $signed(a) >= 0;
      3'd4:    return $signed(a) >  0;
      3'd5:    return $signed(a) <= 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] k, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] t, input logic e);
    bus.in_valid = v;
    bus.in_kind  = k;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
    drv_exp      = e;
  endtask

  task automatic drain(input string name);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && count != '0; i++) step();
    @(negedge clk);
    check({name, "_count"}, 32'(count), 32'd0);
    check({name, "_sb_left"}, 32'(sbq.size()), 32'd0);
    step();
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, i.e. what the DUT will act on at the next edge.
  always @(negedge clk) begin
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got tag %0h with nothing queued", bus.out_tag);
        end else begin
          mon_e = sbq.pop_front();
          check("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
          check("out_taken", 32'(bus.out_taken), 32'(mon_e.taken));
          pops++;
        end
      end
      if (bus.in_valid && bus.in_ready) sbq.push_back('{bus.in_tag, drv_exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;

    vecs[0]  = '{COND_EQ,     32'd5, 32'd5, 8'd0,  1'b1};
    vecs[1]  = '{COND_NE,     32'd5, 32'd5, 8'd1,  1'b0};
    vecs[2]  = '{COND_LTZ,    32'd5, 32'd5, 8'd2,  1'b0};
    vecs[3]  = '{COND_GEZ,    32'd5, 32'd5, 8'd3,  1'b1};
    vecs[4]  = '{COND_GTZ,    32'd5, 32'd5, 8'd4,  1'b1};
    vecs[5]  = '{COND_LEZ,    32'd5, 32'd5, 8'd5,  1'b0};
    vecs[6]  = '{COND_ALWAYS, 32'd5, 32'd5, 8'd6,  1'b1};
    vecs[7]  = '{COND_NEVER,  32'd5, 32'd5, 8'd7,  1'b0};
    vecs[8]  = '{COND_EQ,     32'hFFFFFFFF, 32'd0, 8'd8,  1'b0};
    vecs[9]  = '{COND_NE,     32'hFFFFFFFF, 32'd0, 8'd9,  1'b1};
    vecs[10] = '{COND_LTZ,    32'hFFFFFFFF, 32'd0, 8'd10, 1'b1};
    vecs[11] = '{COND_GEZ,    32'hFFFFFFFF, 32'd0, 8'd11, 1'b0};
    vecs[12] = '{COND_GTZ,    32'hFFFFFFFF, 32'd0, 8'd12, 1'b0};
    vecs[13] = '{COND_LEZ,    32'hFFFFFFFF, 32'd0, 8'd13, 1'b1};
    vecs[14] = '{COND_ALWAYS, 32'hFFFFFFFF, 32'd0, 8'd14, 1'b1};
    vecs[15] = '{COND_NEVER,  32'hFFFFFFFF, 32'd0, 8'd15, 1'b0};
    vecs[16] = '{COND_LTZ,    32'd0, 32'd9, 8'd16, 1'b0};
    vecs[17] = '{COND_GEZ,    32'd0, 32'd9, 8'd17, 1'b1};
    vecs[18] = '{COND_GTZ,    32'd0, 32'd9, 8'd18, 1'b0};
    vecs[19] = '{COND_LEZ,    32'd0, 32'd9, 8'd19, 1'b1};

    drive(1'b0, 3'd0, 32'd0, 32'd0, 8'd0, 1'b0);
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_tag", 32'(bus.out_tag), 32'd0);
    check("rst_out_taken", 32'(bus.out_taken), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // Kind sweep and zero boundary from the vector table
    p0 = pops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp);
      step();
    end
    drain("table");
    check("table_pops", 32'(pops - p0), 32'd20);

    // Fill to full, hold the 5th request, then pop while full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, COND_ALWAYS, 32'd0, 32'd0, 8'(i), 1'b1);
      step();
    end
    drive(1'b1, COND_ALWAYS, 32'd0, 32'd0, 8'd4, 1'b1);
    @(negedge clk);
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    check("fill_held_count", 32'(count), 32'd4);
    check("fill_held_tag", 32'(bus.out_tag), 32'd0);
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("fullpop_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    check("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_pop_count", 32'(count), 32'd3);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("fifth_accept_count", 32'(count), 32'd3);
    step();
    drain("fill");

    // Steady push+pop at count=2: 10 cycles wraps the 2-bit pointers more than twice
    bus.out_ready = 1'b0;
    drive(1'b1, COND_EQ, 32'd7, 32'd7, 8'd40, 1'b1);
    step();
    drive(1'b1, COND_NEVER, 32'd7, 32'd7, 8'd41, 1'b0);
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'(i % 8), 32'(i) - 32'd4, 32'd1, 8'(42 + i),
            model(3'(i % 8), 32'(i) - 32'd4, 32'd1));
      @(negedge clk);
      check("steady_count", 32'(count), 32'd2);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("steady_end_count", 32'(count), 32'd2);
    step();
    drain("steady");

    // Flush at count=3 with a concurrent request
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, COND_GEZ, 32'd3, 32'd0, 8'(60 + i), 1'b1);
      step();
    end
    drive(1'b1, COND_ALWAYS, 32'd0, 32'd0, 8'd99, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    check("flush_pre_count", 32'(count), 32'd3);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    flush = 1'b0;
    drive(1'b1, COND_LTZ, 32'd1, 32'd0, 8'd70, 1'b0);
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_out_valid", 32'(bus.out_valid), 32'd1);
    check("post_flush_tag", 32'(bus.out_tag), 32'd70);
    check("post_flush_count", 32'(count), 32'd1);
    step();
    drain("flush");

    // Reset mid-stream at count=2
    bus.out_ready = 1'b0;
    drive(1'b1, COND_ALWAYS, 32'd0, 32'd0, 8'hA5, 1'b1);
    step();
    drive(1'b1, COND_ALWAYS, 32'd0, 32'd0, 8'hA6, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("prerst_count", 32'(count), 32'd2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_tag", 32'(bus.out_tag), 32'd0);
    check("midrst_out_taken", 32'(bus.out_taken), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    step();

`ifdef BRANCH_COND_STATS_EN
    // Stats: 3 accepts, 2 taken; unchanged by flush; cleared by rst
    check("stat_total_rst", 32'(stat_total), 32'd0);
    check("stat_taken_rst", 32'(stat_taken), 32'd0);
    drive(1'b1, COND_ALWAYS, 32'd0, 32'd0, 8'd80, 1'b1);
    step();
    drive(1'b1, COND_NEVER, 32'd0, 32'd0, 8'd81, 1'b0);
    step();
    drive(1'b1, COND_EQ, 32'd2, 32'd2, 8'd82, 1'b1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stat_total", 32'(stat_total), 32'd3);
    check("stat_taken", 32'(stat_taken), 32'd2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("stat_total_flush", 32'(stat_total), 32'd3);
    check("stat_taken_flush", 32'(stat_taken), 32'd2);
    check("stat_flush_count", 32'(count), 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("stat_total_clr", 32'(stat_total), 32'd0);
    check("stat_taken_clr", 32'(stat_taken), 32'd0);
    step();
`endif

    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
